chime_sequencer: RTL and testbench

- Controller that sequences the Westminster chime resource from the BCD time outputs of the 12-hour clock (hh, mm, ss, pm).
- On each quarter-hour boundary it plays the correct number of four-note "changes" from a fixed 5-change table.
- On the hour, after the changes, it emits one strike pulse per hour.
- Sits beside the clock core and drives the chime/bell output stage.

---
 rtl/chime_pkg.sv | 38 +++
 rtl/chime_slot_timer.sv | 32 +++
 rtl/chime_sequencer.sv | 165 ++++++++++++++++
 tb/tb_chime_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/chime_pkg.sv
// Shared types and constants for the Westminster chime sequencer: FSM states, pitch codes,
// the change table, quarter-hour plans and the BCD hour helper.
package chime_pkg;

    typedef enum logic [2:0] {StIdle, StNote, StGap, StStrikeGap, StStrike} state_e;

    localparam logic [1:0] PitchB3  = 2'd0;
    localparam logic [1:0] PitchE4  = 2'd1;
    localparam logic [1:0] PitchFs4 = 2'd2;
    localparam logic [1:0] PitchGs4 = 2'd3;

    localparam logic [1:0] ChangeTable [5][4] = '{
        '{PitchGs4, PitchFs4, PitchE4,  PitchB3},
        '{PitchE4,  PitchGs4, PitchFs4, PitchB3},
        '{PitchE4,  PitchFs4, PitchGs4, PitchE4},
        '{PitchGs4, PitchE4,  PitchFs4, PitchB3},
        '{PitchB3,  PitchFs4, PitchGs4, PitchE4}
    };

    // Indexed by quarter-1 (0 = :15 ... 3 = :00)
    localparam logic [2:0] QuarterStart [4] = '{3'd0, 3'd1, 3'd3, 3'd1};
    localparam logic [2:0] QuarterCount [4] = '{3'd1, 3'd2, 3'd3, 3'd4};

    localparam int unsigned TimerWidth = 16;

    function automatic logic [3:0] bcd_hour(input logic [7:0] bcd);
        logic [7:0] bin;
        bin = 8'(bcd[7:4]) * 8'd10 + 8'(bcd[3:0]);
        if (bin == 8'd0 || bin > 8'd12) return 4'd12;
        return bin[3:0];
    endfunction

    function automatic logic night_window(input logic [3:0] hour, input logic pm);
        if (pm) return (hour == 4'd10) || (hour == 4'd11);
        return (hour == 4'd12) || (hour <= 4'd6);
    endfunction

endpackage

// File: rtl/chime_slot_timer.sv
// Slot down-counter: load with a length, flags the first and last cycle of the slot.
module chime_slot_timer #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] len,
    output logic             slot_start,
    output logic             slot_done
);

    logic [Width-1:0] cnt_q;
    logic             first_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else if (load) begin
            cnt_q   <= len - Width'(1);
            first_q <= 1'b1;
        end else begin
            first_q <= 1'b0;
            if (cnt_q != '0) cnt_q <= cnt_q - Width'(1);
        end
    end

    assign slot_start = first_q;
    assign slot_done  = (cnt_q == '0);

endmodule

// File: rtl/chime_sequencer.sv
// Westminster chime sequencer: plays quarter-hour changes and hour strikes from BCD time.
// Optional macro CHIME_NIGHT_MUTE_EN discards triggers between 10 PM and 6:45 AM.
module chime_sequencer
    import chime_pkg::*;
#(
    parameter int unsigned NOTE_CYCLES   = 4,
    parameter int unsigned GAP_CYCLES    = 8,
    parameter int unsigned STRIKE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic       pm,
    output logic       note_valid,
    output logic [1:0] note_pitch,
    output logic       strike,
    output logic       busy,
    output logic       overrun
);

    state_e                state_q, state_d;
    logic [1:0]            qidx_q, qidx_d;
    logic [3:0]            hours_q, hours_d;
    logic [2:0]            chg_q, chg_d;
    logic [2:0]            left_q, left_d;
    logic [1:0]            note_q, note_d;
    logic [3:0]            strikes_q, strikes_d;
    logic                  match, match_q, trig, mute, overrun_q;
    logic                  load, slot_start, slot_done;
    logic [TimerWidth-1:0] len;

    assign match = (ss == 8'h00) &&
                   (mm == 8'h00 || mm == 8'h15 || mm == 8'h30 || mm == 8'h45);
    assign trig  = match & ~match_q;

`ifdef CHIME_NIGHT_MUTE_EN
    assign mute = night_window(bcd_hour(hh), pm);
`else
    logic unused_pm;
    assign unused_pm = pm;
    assign mute      = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        qidx_d    = qidx_q;
        hours_d   = hours_q;
        chg_d     = chg_q;
        left_d    = left_q;
        note_d    = note_q;
        strikes_d = strikes_q;
        load      = 1'b0;
        len       = TimerWidth'(NOTE_CYCLES);
        unique case (state_q)
            StIdle: begin
                if (trig && !mute) begin
                    unique case (mm)
                        8'h15:   qidx_d = 2'd0;
                        8'h30:   qidx_d = 2'd1;
                        8'h45:   qidx_d = 2'd2;
                        default: qidx_d = 2'd3;
                    endcase
                    state_d = StNote;
                    load    = 1'b1;
                    hours_d = bcd_hour(hh);
                    chg_d   = QuarterStart[qidx_d];
                    left_d  = QuarterCount[qidx_d];
                    note_d  = 2'd0;
                end
            end
            StNote: begin
                if (slot_done) begin
                    if (note_q != 2'd3) begin
                        note_d = note_q + 2'd1;
                        load   = 1'b1;
                    end else if (left_q > 3'd1) begin
                        state_d = StGap;
                        load    = 1'b1;
                        len     = TimerWidth'(GAP_CYCLES);
                    end else if (qidx_q == 2'd3) begin
                        state_d = StStrikeGap;
                        load    = 1'b1;
                        len     = TimerWidth'(GAP_CYCLES);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGap: begin
                // Advance the change only on leaving the gap so the last pitch is held.
                if (slot_done) begin
                    state_d = StNote;
                    load    = 1'b1;
                    note_d  = 2'd0;
                    left_d  = left_q - 3'd1;
                    chg_d   = (chg_q == 3'd4) ? 3'd0 : chg_q + 3'd1;
                end
            end
            StStrikeGap: begin
                if (slot_done) begin
                    state_d   = StStrike;
                    load      = 1'b1;
                    len       = TimerWidth'(STRIKE_CYCLES);
                    strikes_d = hours_q;
                end
            end
            StStrike: begin
                if (slot_done) begin
                    if (strikes_q > 4'd1) begin
                        strikes_d = strikes_q - 4'd1;
                        load      = 1'b1;
                        len       = TimerWidth'(STRIKE_CYCLES);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            qidx_q    <= '0;
            hours_q   <= '0;
            chg_q     <= '0;
            left_q    <= '0;
            note_q    <= '0;
            strikes_q <= '0;
            match_q   <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            qidx_q    <= qidx_d;
            hours_q   <= hours_d;
            chg_q     <= chg_d;
            left_q    <= left_d;
            note_q    <= note_d;
            strikes_q <= strikes_d;
            match_q   <= match;
            overrun_q <= overrun_q | (trig && (state_q != StIdle));
        end
    end

    chime_slot_timer #(
        .Width(TimerWidth)
    ) u_slot_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .len        (len),
        .slot_start (slot_start),
        .slot_done  (slot_done)
    );

    assign busy       = (state_q != StIdle);
    assign note_valid = (state_q == StNote) && slot_start;
    assign strike     = (state_q == StStrike) && slot_start;
    assign note_pitch = (state_q == StIdle) ? PitchB3 : ChangeTable[chg_q][note_q];
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_chime_sequencer.sv
// Scoreboard bench for chime_sequencer: expected note/strike events are queued when the time
// changes and matched against DUT pulses.
module tb_chime_sequencer;

    localparam int N = 4;
    localparam int G = 8;
    localparam int S = 16;

    typedef struct {
        bit         is_strike;
        logic [1:0] pitch;
        int         cycle;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] hh = 8'h12, mm = 8'h00, ss = 8'h00;
    logic       pm = 1'b1;
    logic       note_valid, strike, busy, overrun;
    logic [1:0] note_pitch;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    ev_t sb[$];
    ev_t mon_ev;

    int unsigned ctab [5][4] = '{'{3, 2, 1, 0}, '{1, 3, 2, 0}, '{1, 2, 3, 1},
                                 '{3, 1, 2, 0}, '{0, 2, 3, 1}};

    chime_sequencer #(
        .NOTE_CYCLES   (N),
        .GAP_CYCLES    (G),
        .STRIKE_CYCLES (S)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hh         (hh),
        .mm         (mm),
        .ss         (ss),
        .pm         (pm),
        .note_valid (note_valid),
        .note_pitch (note_pitch),
        .strike     (strike),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (note_valid || strike) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'({note_valid, strike}), 32'd0);
            end else begin
                mon_ev = sb.pop_front();
                check("pulse_kind", 32'(strike), 32'(mon_ev.is_strike));
                check("pulse_cycle", cyc, mon_ev.cycle);
                if (!mon_ev.is_strike) check("note_pitch", 32'(note_pitch), 32'(mon_ev.pitch));
            end
        end
    end

    // Queue the expected pulses for quarter q (1..4) starting at t0; returns busy-fall cycle.
    function automatic int push_plan(input int q, input int hours, input int t0);
        int   start, cnt, base;
        ev_t  e;
        case (q)
            1:       begin start = 0; cnt = 1; end
            2:       begin start = 1; cnt = 2; end
            3:       begin start = 3; cnt = 3; end
            default: begin start = 1; cnt = 4; end
        endcase
        for (int c = 0; c < cnt; c++) begin
            for (int j = 0; j < 4; j++) begin
                e.is_strike = 1'b0;
                e.pitch     = 2'(ctab[(start + c) % 5][j]);
                e.cycle     = t0 + (c * 4 + j) * N + c * G;
                sb.push_back(e);
            end
        end
        if (q != 4) return t0 + cnt * 4 * N + (cnt - 1) * G;
        base = t0 + 16 * N + 4 * G;
        for (int s = 0; s < hours; s++) begin
            e.is_strike = 1'b1;
            e.pitch     = 2'd0;
            e.cycle     = base + s * S;
            sb.push_back(e);
        end
        return base + hours * S;
    endfunction

    task automatic run_seq(input logic [7:0] h_pre, input logic [7:0] m_pre,
                           input logic [7:0] h, input logic [7:0] m, input logic p,
                           input int q, input int hours, input bit muted, input int glitch_at);
        int t0, end_c;
        @(negedge clk);
        hh = h_pre; mm = m_pre; ss = 8'h59; pm = p;
        repeat (3) @(negedge clk);
        hh = h; mm = m; ss = 8'h00;
        t0    = cyc + 1;
        end_c = muted ? t0 : push_plan(q, hours, t0);
        while (cyc < end_c + 3) begin
            @(negedge clk);
            if (!muted && cyc == t0) check("busy_rise", 32'(busy), 32'd1);
            if (!muted && cyc == end_c - 1) check("busy_hold", 32'(busy), 32'd1);
            if (cyc == end_c) check("busy_end", 32'(busy), 32'd0);
            if (glitch_at >= 0 && cyc == t0 + glitch_at) ss = 8'h01;
            if (glitch_at >= 0 && cyc == t0 + glitch_at + 1) ss = 8'h00;
        end
        check("sb_drained", sb.size(), 32'd0);
        check("overrun_flag", 32'(overrun), 32'(glitch_at >= 0));
        ss = 8'h01;
    endtask

    initial begin
        int t0;
        // Reset held with the clock reading 12:00:00.
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_note_valid", 32'(note_valid), 32'd0);
        check("rst_strike", 32'(strike), 32'd0);
        check("rst_pitch", 32'(note_pitch), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("no_trig_at_release", 32'(busy), 32'd0);
        ss = 8'h01;

        run_seq(8'h12, 8'h14, 8'h12, 8'h15, 1'b1, 1, 12, 1'b0, -1);
        run_seq(8'h03, 8'h44, 8'h03, 8'h45, 1'b1, 3, 3, 1'b0, -1);
        run_seq(8'h02, 8'h59, 8'h03, 8'h00, 1'b1, 4, 3, 1'b0, -1);
        run_seq(8'h11, 8'h59, 8'h12, 8'h00, 1'b1, 4, 12, 1'b0, -1);
`ifdef CHIME_NIGHT_MUTE_EN
        run_seq(8'h10, 8'h59, 8'h11, 8'h00, 1'b1, 4, 11, 1'b1, -1);
`else
        run_seq(8'h10, 8'h59, 8'h11, 8'h00, 1'b1, 4, 11, 1'b0, -1);
`endif
        run_seq(8'h06, 8'h59, 8'h07, 8'h00, 1'b0, 4, 7, 1'b0, -1);
        // Second match edge mid-sequence must not disturb it.
        run_seq(8'h01, 8'h29, 8'h01, 8'h30, 1'b1, 2, 1, 1'b0, 10);

        // Reset in the middle of the first note slot.
        @(negedge clk);
        hh = 8'h01; mm = 8'h14; ss = 8'h59; pm = 1'b1;
        repeat (3) @(negedge clk);
        mm = 8'h15; ss = 8'h00;
        t0 = cyc + 1;
        void'(push_plan(1, 1, t0));
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        sb.delete();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pitch", 32'(note_pitch), 32'd0);
        check("abort_note_valid", 32'(note_valid), 32'd0);
        check("abort_strike", 32'(strike), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("post_abort_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
